// File: rtl/issue_queue.sv
// In-order decode-to-exec instruction FIFO; 1-cycle minimum latency, no bypass.
// Enqueue stalls only on full; flush discards all entries synchronously.
module issue_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     decoded_valid_i,
    output logic                     decoded_ready_o,
    input  logic [DATA_W-1:0]        decoded_data_i,
    output logic                     issue_valid_o,
    input  logic                     issue_ready_i,
    output logic [DATA_W-1:0]        issue_data_o,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   occupancy_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       rptr_q, rptr_d;
    logic [AW:0]       wptr_q, wptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              empty, full, enq_fire, deq_fire;

    assign empty = (rptr_q == wptr_q);
    assign full  = (rptr_q[AW-1:0] == wptr_q[AW-1:0]) && (rptr_q[AW] != wptr_q[AW]);

    // Ready depends only on fullness so exec back-pressure never reaches decode combinationally.
    assign decoded_ready_o = !full;
    assign issue_valid_o   = !empty;
    assign issue_data_o    = mem_q[rptr_q[AW-1:0]];
    assign occupancy_o     = wptr_q - rptr_q;

    assign enq_fire = decoded_valid_i && decoded_ready_o;
    assign deq_fire = issue_valid_o && issue_ready_i;

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        if (flush_i) begin
            rptr_d = '0;
            wptr_d = '0;
        end else begin
            if (enq_fire) wptr_d = wptr_q + 1'b1;
            if (deq_fire) rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
    end

    // Payload storage needs no reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (enq_fire && !flush_i) begin
            mem_q[wptr_q[AW-1:0]] <= decoded_data_i;
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              dv = 1'b0;
    logic              dr;
    logic [DATA_W-1:0] din = '0;
    logic              iv;
    logic              ir = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              flush = 1'b0;
    logic [2:0]        occ;

    int total = 0;
    int bad   = 0;
    int fires = 0;
    logic [DATA_W-1:0] sb[$];

    issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .decoded_valid_i (dv),
        .decoded_ready_o (dr),
        .decoded_data_i  (din),
        .issue_valid_o   (iv),
        .issue_ready_i   (ir),
        .issue_data_o    (dout),
        .flush_i         (flush),
        .occupancy_o     (occ)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk(input logic [31:0] pc);
        return {pc ^ 32'hC0DE_0000, pc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; check against the model, then advance it.
    task automatic tick();
        logic enq, deq;
        #1;
        chk("occ", 64'(occ), 64'(sb.size()));
        chk("issue_valid", 64'(iv), 64'(sb.size() != 0));
        chk("decoded_ready", 64'(dr), 64'(sb.size() != DEPTH));
        enq = dv && (sb.size() < DEPTH);
        deq = ir && (sb.size() != 0);
        if (deq) chk("issue_data", dout, sb[0]);
        @(posedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (deq) begin
                void'(sb.pop_front());
                fires++;
            end
            if (enq) sb.push_back(din);
        end
        @(negedge clk);
    endtask

    task automatic enq_only(input logic [31:0] pc);
        dv = 1'b1; ir = 1'b0; din = mk(pc);
        tick();
    endtask

    initial begin
        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ivalid", 64'(iv), 64'd0);
        chk("rst_dready", 64'(dr), 64'd1);
        chk("rst_occ", 64'(occ), 64'd0);
        rst = 1'b1;
        tick();

        // Fill with exec stalled, then a held 5th instruction
        for (int i = 0; i < 4; i++) enq_only(32'h100 + 32'(4 * i));
        #1;
        chk("full_dready", 64'(dr), 64'd0);
        chk("full_occ", 64'(occ), 64'd4);
        dv = 1'b1; din = mk(32'h110);
        tick();
        chk("held_occ", 64'(occ), 64'd4);
        dv = 1'b0; ir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_occ", 64'(occ), 64'(4 - i));
            chk("drain_pc", dout, mk(32'h100 + 32'(4 * i)));
            tick();
        end
        chk("drained_occ", 64'(occ), 64'd0);

        // Streaming 20 instructions through, wrapping the pointers
        fires = 0;
        ir = 1'b1;
        for (int i = 0; i < 20; i++) begin
            dv = 1'b1; din = mk(32'h400 + 32'(4 * i));
            tick();
            if (i > 0) chk("stream_occ", 64'(occ), 64'd1);
        end
        dv = 1'b0;
        tick();
        chk("stream_fires", 64'(fires), 64'd20);
        chk("stream_empty", 64'(iv), 64'd0);

        // Full with simultaneous dequeue: enqueue blocked for one cycle
        for (int i = 0; i < 4; i++) enq_only(32'h500 + 32'(4 * i));
        dv = 1'b1; ir = 1'b1; din = mk(32'h510);
        tick();
        chk("fulldeq_occ", 64'(occ), 64'd3);
        tick();
        chk("fulldeq_next_occ", 64'(occ), 64'd3);
        dv = 1'b0;
        repeat (3) tick();
        chk("fulldeq_drained", 64'(occ), 64'd0);

        // Flush coinciding with both enqueue and dequeue fires
        for (int i = 0; i < 3; i++) enq_only(32'h600 + 32'(4 * i));
        dv = 1'b1; ir = 1'b1; flush = 1'b1; din = mk(32'h60C);
        tick();
        flush = 1'b0;
        chk("flush_occ", 64'(occ), 64'd0);
        chk("flush_ivalid", 64'(iv), 64'd0);
        enq_only(32'h200);
        dv = 1'b0; ir = 1'b1;
        #1;
        chk("post_flush_pc", dout, mk(32'h200));
        tick();

        // Empty queue: no bypass from decode to issue
        dv = 1'b1; ir = 1'b1; din = mk(32'h300);
        #1;
        chk("bypass_ivalid0", 64'(iv), 64'd0);
        tick();
        dv = 1'b0;
        #1;
        chk("bypass_ivalid1", 64'(iv), 64'd1);
        chk("bypass_pc", dout, mk(32'h300));
        tick();

        // Asynchronous reset mid-stream with 3 entries
        for (int i = 0; i < 3; i++) enq_only(32'h700 + 32'(4 * i));
        dv = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ivalid", 64'(iv), 64'd0);
        chk("arst_dready", 64'(dr), 64'd1);
        chk("arst_occ", 64'(occ), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/issue_queue.md
# issue_queue

In-order FIFO between the decode stage and the execution units. It buffers decoded instructions and presents them one at a time, in program order, on a decoupled port to the exec stage (misc unit and siblings). It decouples decode stalls from exec back-pressure and discards all buffered work on a pipeline flush, such as a taken JALR redirect.

## Interface

Parameters:
- DEPTH, default 4: number of entries. Power of two, DEPTH >= 2.

Ports:
- clk  input  1: clock; all state updates on the rising edge.
- rst  input  1: asynchronous, active-low reset. Asserting low clears state immediately; deassertion is synchronous to clk.
- decoded  decoupled.in  (data: decoded instruction struct): enqueue port from decode. Fire = valid & ready.
- issue  decoupled.out  (data: decoded instruction struct): dequeue port to exec units. Fire = valid & ready.
- flush  input  1: synchronous discard of all entries.
- occupancy  output  $clog2(DEPTH)+1: current entry count, 0..DEPTH.

## Operation

- Storage:
  - DEPTH-entry array of decoded-instruction structs.
  - Read and write pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = (rptr == wptr).
  - full = index bits equal and wrap bits differ.
- Enqueue:
  - decoded.ready = !full. It does not look at issue.ready, so there is no combinational path from exec to decode.
  - On a decoded fire: write entry[wptr index], then wptr += 1.
- Dequeue:
  - issue.valid = !empty.
  - issue.data = entry[rptr index], read combinationally from the array.
  - On an issue fire: rptr += 1.
- Simultaneous enqueue and dequeue:
  - Both pointers advance and occupancy is unchanged.
  - When full, enqueue is blocked even if a dequeue fires that cycle.
  - When empty, the new entry is not visible on issue until the next cycle. There is no bypass.
- Flush:
  - When flush=1: rptr and wptr both go to 0, and any enqueue or dequeue fire in that cycle has no effect on state.
  - decoded.ready and issue.valid are not gated by flush. The upstream and downstream stages see flush themselves and must drop their own transfers.
  - Entry contents are not cleared.
- Pointer wrap: natural modulo-2·DEPTH overflow. Index = low bits.
- occupancy = wptr − rptr, computed modulo 2·DEPTH. It is registered-derived; no combinational input feeds it.
- Order is strictly FIFO. No reordering, no dependency checks. Hazard handling lives in the issue logic upstream of exec operand read.

## Timing

- Reset values (while rst=0): rptr=0, wptr=0, issue.valid=0, decoded.ready=1, occupancy=0. issue.data is don't-care.
- Latency: an instruction accepted in cycle N appears on issue with valid=1 in cycle N+1 at the earliest.
- Throughput: 1 enqueue and 1 dequeue per cycle, sustained.
- decoded.ready and issue.valid are pure functions of registered state.
- Reset asserted mid-operation: all entries are lost at once, and outputs take their reset values in the same cycle, asynchronously.
- Flush in cycle N: in cycle N+1, issue.valid=0, occupancy=0, decoded.ready=1.

## Test plan

- Reset: hold rst=0 for 3 cycles, then release → issue.valid=0, decoded.ready=1, occupancy=0. Assert rst=0 mid-stream with 3 entries → outputs return to reset values without waiting for a clock edge.
- Fill and drain, DEPTH=4, issue.ready=0: enqueue pc=0x100, 0x104, 0x108, 0x10C → decoded.ready=0 after the 4th, occupancy=4. A 5th valid is held and not accepted. Set issue.ready=1 → pcs emerge in order, one per cycle, and occupancy counts down 4,3,2,1,0.
- Streaming: continuous valid on both sides for 20 instructions → after 1 cycle of latency, one issue per cycle, occupancy stays at 1, all pcs in order, and the pointers wrap past 2·DEPTH correctly.
- Full with simultaneous dequeue: occupancy=4, issue.ready=1, decoded.valid=1 → the dequeue fires, the enqueue does not, occupancy=3. The next cycle the enqueue fires and occupancy stays 3.
- Flush: 3 entries queued, with flush=1 together with an enqueue and a dequeue fire → next cycle occupancy=0, issue.valid=0. A subsequent enqueue of pc=0x200 is the first instruction issued.
- Empty bypass check: empty queue, enqueue pc=0x300 with issue.ready=1 → issue.valid=0 in the accept cycle and 1 with pc=0x300 in the next cycle.
